// File: rtl/elevator_pkg.sv
// Shared encodings for the SCAN elevator controller: FSM states, actuator
// command codes and door sensor codes.
package elevator_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLOSING,
      S_MOVING,
      S_OPENING,
      S_OPEN_WAIT,
      S_FAULT
   } state_t;

   localparam logic [1:0] ENG_STOP = 2'b00;
   localparam logic [1:0] ENG_UP   = 2'b01;
   localparam logic [1:0] ENG_DOWN = 2'b10;

   localparam logic [1:0] DR_HOLD  = 2'b00;
   localparam logic [1:0] DR_OPEN  = 2'b01;
   localparam logic [1:0] DR_CLOSE = 2'b10;

   localparam logic [1:0] SENS_MID    = 2'b00;
   localparam logic [1:0] SENS_OPEN   = 2'b01;
   localparam logic [1:0] SENS_CLOSED = 2'b10;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/elevator_call_reg.sv
// Latched car and hall call registers with per-level clear and
// combinational here/above/below summary flags for a queried level.
module elevator_call_reg
   import elevator_pkg::*;
#(
   parameter int FLOORS  = 8,
   parameter int LEVEL_W = 3
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               en,
   input  logic               clr_car,
   input  logic               clr_up,
   input  logic               clr_down,
   input  logic [FLOORS-1:0]  btn_in,
   input  logic [FLOORS-2:0]  btn_up_out,
   input  logic [FLOORS-1:1]  btn_down_out,
   input  logic [LEVEL_W-1:0] lvl,
   output logic               car_here,
   output logic               up_here,
   output logic               down_here,
   output logic               any_above,
   output logic               any_below
);

   logic [FLOORS-1:0] car_q, up_q, dn_q;
   logic [FLOORS-1:0] up_set, dn_set, all_calls;
   logic [FLOORS-1:0] here_mask, below_mask, above_mask;

   always_comb begin
      up_set = '0;
      dn_set = '0;
      up_set[FLOORS-2:0] = btn_up_out;
      dn_set[FLOORS-1:1] = btn_down_out;
   end

   assign here_mask  = FLOORS'(1) << lvl;
   assign below_mask = here_mask - FLOORS'(1);
   assign above_mask = ~(below_mask | here_mask);
   assign all_calls  = car_q | up_q | dn_q;

   // Clear wins over a same-cycle press so a call at an open door never latches.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         car_q <= '0;
         up_q  <= '0;
         dn_q  <= '0;
      end else begin
         car_q <= (car_q | ({FLOORS{en}} & btn_in)) & ~({FLOORS{clr_car}}  & here_mask);
         up_q  <= (up_q  | ({FLOORS{en}} & up_set)) & ~({FLOORS{clr_up}}   & here_mask);
         dn_q  <= (dn_q  | ({FLOORS{en}} & dn_set)) & ~({FLOORS{clr_down}} & here_mask);
      end
   end

   assign car_here  = |(car_q & here_mask);
   assign up_here   = |(up_q & here_mask);
   assign down_here = |(dn_q & here_mask);
   assign any_above = |(all_calls & above_mask);
   assign any_below = |(all_calls & below_mask);

endmodule

// File: rtl/elevator_scan.sv
// SCAN (collective) car controller: FSM, shared door/travel timer and level
// counter around the call register block.
module elevator_scan
   import elevator_pkg::*;
#(
   parameter int FLOORS    = 8,
   parameter int LEVEL_W   = 3,
   parameter int DOOR_HOLD = 20,
   parameter int TRAVEL_TO = 200
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               open_btn,
   input  logic               close_btn,
   input  logic               overload,
   input  logic               sensor_inside,
   input  logic               sensor_up,
   input  logic               sensor_down,
   input  logic [1:0]         sensor_door,
   input  logic [FLOORS-1:0]  btn_in,
   input  logic [FLOORS-2:0]  btn_up_out,
   input  logic [FLOORS-1:1]  btn_down_out,
   output logic [1:0]         engine,
   output logic [1:0]         door,
   output logic               direction,
   output logic [LEVEL_W-1:0] level_display,
   output logic               fault
);

   localparam int TW = $clog2(max_int(DOOR_HOLD, TRAVEL_TO)) + 1;
   localparam logic [TW-1:0]      HOLD_LAST   = TW'(DOOR_HOLD - 1);
   localparam logic [TW-1:0]      TRAVEL_LAST = TW'(TRAVEL_TO - 1);
   localparam logic [LEVEL_W-1:0] TOP         = LEVEL_W'(FLOORS - 1);

   state_t             state, state_n, sched_state;
   logic [LEVEL_W-1:0] level, level_n, step_lvl, query_lvl;
   logic               dir, dir_n, sched_flip;
   logic [TW-1:0]      tmr, tmr_n, tmr_inc;
   logic               pulse_ok, door_open_phase;
   logic               car_here, up_here, down_here, any_above, any_below;
   logic               dir_hall_here, opp_hall_here, ahead, behind;

   assign pulse_ok = dir ? (sensor_up & ~sensor_down) : (sensor_down & ~sensor_up);
   assign step_lvl = dir ? ((level == TOP) ? level : level + LEVEL_W'(1))
                         : ((level == '0)  ? level : level - LEVEL_W'(1));
   // While moving, stop decisions look at the floor being arrived at.
   assign query_lvl = (state == S_MOVING && pulse_ok) ? step_lvl : level;
   assign door_open_phase = (state == S_OPENING) || (state == S_OPEN_WAIT);
   assign tmr_inc = (tmr == '1) ? tmr : tmr + TW'(1);

   elevator_call_reg #(
      .FLOORS  (FLOORS),
      .LEVEL_W (LEVEL_W)
   ) u_calls (
      .clk          (clk),
      .reset        (reset),
      .en           (state != S_FAULT),
      .clr_car      (door_open_phase),
      .clr_up       (door_open_phase & dir),
      .clr_down     (door_open_phase & ~dir),
      .btn_in       (btn_in),
      .btn_up_out   (btn_up_out),
      .btn_down_out (btn_down_out),
      .lvl          (query_lvl),
      .car_here     (car_here),
      .up_here      (up_here),
      .down_here    (down_here),
      .any_above    (any_above),
      .any_below    (any_below)
   );

   assign dir_hall_here = dir ? up_here : down_here;
   assign opp_hall_here = dir ? down_here : up_here;
   assign ahead         = dir ? any_above : any_below;
   assign behind        = dir ? any_below : any_above;

   always_comb begin
      sched_state = S_IDLE;
      sched_flip  = 1'b0;
      if (car_here || dir_hall_here) begin
         sched_state = S_OPENING;
      end else if (ahead) begin
         sched_state = S_CLOSING;
      end else if (opp_hall_here) begin
         sched_state = S_OPENING;
         sched_flip  = 1'b1;
      end else if (behind) begin
         sched_state = S_CLOSING;
         sched_flip  = 1'b1;
      end
   end

   always_comb begin
      state_n = state;
      level_n = level;
      dir_n   = dir;
      tmr_n   = tmr;
      case (state)
         S_IDLE: begin
            state_n = sched_state;
            dir_n   = dir ^ sched_flip;
         end
         S_CLOSING: begin
            if (open_btn || sensor_inside || overload) begin
               state_n = S_OPENING;
            end else if (sensor_door == SENS_CLOSED) begin
               state_n = S_MOVING;
               tmr_n   = '0;
            end
         end
         S_MOVING: begin
            if (pulse_ok) begin
               level_n = step_lvl;
               tmr_n   = '0;
               if (car_here || dir_hall_here || !ahead) begin
                  state_n = S_OPENING;
                  if (!ahead && !dir_hall_here && opp_hall_here) dir_n = ~dir;
               end
            end else if (tmr >= TRAVEL_LAST) begin
               state_n = S_FAULT;
            end else begin
               tmr_n = tmr_inc;
            end
         end
         S_OPENING: begin
            if (sensor_door == SENS_OPEN) begin
               state_n = S_OPEN_WAIT;
               tmr_n   = '0;
            end
         end
         S_OPEN_WAIT: begin
            if (open_btn || sensor_inside) begin
               tmr_n = '0;
            end else if (!overload && (close_btn || tmr >= HOLD_LAST)) begin
               state_n = sched_state;
               dir_n   = dir ^ sched_flip;
            end else begin
               tmr_n = tmr_inc;
            end
         end
         default: ;
      endcase
      if (state != S_FAULT) begin
         if (level_n == TOP) dir_n = 1'b0;
         else if (level_n == '0) dir_n = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= S_IDLE;
         level <= '0;
         dir   <= 1'b1;
         tmr   <= '0;
      end else begin
         state <= state_n;
         level <= level_n;
         dir   <= dir_n;
         tmr   <= tmr_n;
      end
   end

   assign engine        = (state == S_MOVING) ? (dir ? ENG_UP : ENG_DOWN) : ENG_STOP;
   assign door          = (state == S_CLOSING) ? DR_CLOSE :
                          (state == S_OPENING) ? DR_OPEN  : DR_HOLD;
   assign direction     = dir;
   assign level_display = level;
   assign fault         = (state == S_FAULT);

endmodule

// File: tb/tb_elevator_scan.sv
// Directed bench for elevator_scan: travel, SCAN stops, door hold/reopen,
// watchdog fault and overload, with hand-computed expectations.
module tb_elevator_scan;

   logic       clk = 1'b0;
   logic       reset;
   logic       open_btn, close_btn, overload, sensor_inside;
   logic       sensor_up, sensor_down;
   logic [1:0] sensor_door;
   logic [7:0] btn_in;
   logic [6:0] btn_up_out;
   logic [7:1] btn_down_out;
   logic [1:0] engine, door;
   logic       direction, fault;
   logic [2:0] level_display;

   int compared   = 0;
   int mismatched = 0;

   elevator_scan #(
      .FLOORS    (8),
      .LEVEL_W   (3),
      .DOOR_HOLD (20),
      .TRAVEL_TO (200)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .open_btn      (open_btn),
      .close_btn     (close_btn),
      .overload      (overload),
      .sensor_inside (sensor_inside),
      .sensor_up     (sensor_up),
      .sensor_down   (sensor_down),
      .sensor_door   (sensor_door),
      .btn_in        (btn_in),
      .btn_up_out    (btn_up_out),
      .btn_down_out  (btn_down_out),
      .engine        (engine),
      .door          (door),
      .direction     (direction),
      .level_display (level_display),
      .fault         (fault)
   );

   always #5 clk = ~clk;

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      compared++;
      assert (obs === exp_v) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   task automatic pulse_up();
      sensor_up = 1'b1;
      tick(1);
      sensor_up = 1'b0;
   endtask

   task automatic pulse_down();
      sensor_down = 1'b1;
      tick(1);
      sensor_down = 1'b0;
   endtask

   initial begin
      reset = 1'b0;
      open_btn = 1'b0; close_btn = 1'b0; overload = 1'b0; sensor_inside = 1'b0;
      sensor_up = 1'b0; sensor_down = 1'b0; sensor_door = 2'b10;
      btn_in = '0; btn_up_out = '0; btn_down_out = '0;
      tick(3);
      reset = 1'b1;
      tick(1);
      chk("rst_engine", engine, 2'b00);
      chk("rst_door", door, 2'b00);
      chk("rst_dir", direction, 1'b1);
      chk("rst_level", level_display, 3'd0);
      chk("rst_fault", fault, 1'b0);

      // 1: car call to floor 6 from floor 0
      btn_in[6] = 1'b1; tick(1); btn_in = '0;
      tick(1);
      chk("t1_closing", door, 2'b10);
      tick(1);
      chk("t1_engine_up", engine, 2'b01);
      repeat (5) pulse_up();
      chk("t1_level5", level_display, 3'd5);
      chk("t1_still_up", engine, 2'b01);
      pulse_up();
      chk("t1_level6", level_display, 3'd6);
      chk("t1_door_open", door, 2'b01);
      chk("t1_engine_stop", engine, 2'b00);

      // 2: up call at 2, down call at 4
      reset = 1'b0; tick(2); reset = 1'b1;
      btn_down_out[4] = 1'b1; btn_up_out[2] = 1'b1; tick(1);
      btn_down_out = '0; btn_up_out = '0;
      tick(2);
      pulse_up();
      chk("t2_level1_moving", engine, 2'b01);
      pulse_up();
      chk("t2_level2", level_display, 3'd2);
      chk("t2_stop_door", door, 2'b01);
      chk("t2_stop_dir", direction, 1'b1);
      sensor_door = 2'b01; tick(1);
      tick(25);
      chk("t2_reclose", door, 2'b10);
      sensor_door = 2'b10; tick(1);
      pulse_down();
      chk("t2_wrong_pulse_level", level_display, 3'd2);
      chk("t2_wrong_pulse_engine", engine, 2'b01);
      pulse_up();
      chk("t2_level3", level_display, 3'd3);
      pulse_up();
      chk("t2_level4", level_display, 3'd4);
      chk("t2_dir_down", direction, 1'b0);
      chk("t2_stop4_door", door, 2'b01);
      sensor_door = 2'b01; tick(1);
      tick(25);
      chk("t2_idle_engine", engine, 2'b00);
      chk("t2_idle_door", door, 2'b00);

      // 3: obstruction holds the door, then 20-cycle hold
      btn_in[4] = 1'b1; tick(1); btn_in = '0;
      tick(1);
      chk("t3_reopen", door, 2'b01);
      tick(1);
      btn_in[1] = 1'b1; sensor_inside = 1'b1; tick(1); btn_in = '0;
      tick(49);
      chk("t3_held", door, 2'b00);
      sensor_inside = 1'b0;
      tick(19);
      chk("t3_hold_19", door, 2'b00);
      tick(1);
      chk("t3_close_20", door, 2'b10);

      // 4: open_btn during closing
      open_btn = 1'b1; tick(1); open_btn = 1'b0;
      chk("t4_reopen_door", door, 2'b01);
      chk("t4_no_engine", engine, 2'b00);
      chk("t4_level", level_display, 3'd4);
      tick(1);

      // 5: travel watchdog
      tick(20);
      chk("t5_closing", door, 2'b10);
      sensor_door = 2'b10; tick(1);
      chk("t5_engine_down", engine, 2'b10);
      sensor_up = 1'b1; sensor_down = 1'b1; tick(1);
      sensor_up = 1'b0; sensor_down = 1'b0;
      chk("t5_both_pulse_level", level_display, 3'd4);
      tick(198);
      chk("t5_fault_199", fault, 1'b0);
      tick(1);
      chk("t5_fault_200", fault, 1'b1);
      chk("t5_fault_engine", engine, 2'b00);
      chk("t5_fault_door", door, 2'b00);
      reset = 1'b0; #2;
      chk("t5_rst_fault", fault, 1'b0);
      chk("t5_rst_level", level_display, 3'd0);
      chk("t5_rst_dir", direction, 1'b1);
      tick(2); reset = 1'b1;

      // 6: overload holds the door at floor 5
      btn_in[5] = 1'b1; tick(1); btn_in = '0;
      tick(2);
      repeat (5) pulse_up();
      chk("t6_level5", level_display, 3'd5);
      sensor_door = 2'b01; tick(1);
      btn_in[0] = 1'b1; overload = 1'b1; close_btn = 1'b1; tick(1); btn_in = '0;
      tick(29);
      chk("t6_held_door", door, 2'b00);
      chk("t6_held_dir", direction, 1'b1);
      overload = 1'b0; tick(1);
      chk("t6_close_door", door, 2'b10);
      chk("t6_dir_flip", direction, 1'b0);
      close_btn = 1'b0;
      sensor_door = 2'b10; tick(1);
      chk("t6_engine_down", engine, 2'b10);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
